branch_predict_unit: RTL and testbench

// - Parametrised branch resolution plus direction-prediction unit for the RISC-V core.
// - Fetch side: indexes a bimodal table of 2-bit saturating counters by PC and returns a taken/not-taken prediction.
// - Execute side: evaluates all six RV32I branch conditions and trains the table.
// - Execute side also reports, one cycle later, a registered redirect (mispredict + correct next PC) to fetch.

---
 rtl/branch_pkg.sv | 30 +++
 rtl/bht_table.sv | 47 ++++
 rtl/branch_predict_unit.sv | 164 ++++++++++++++++
 tb/tb_branch_predict_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch predict unit.
//   br_op_e   : RV32I conditional-branch funct3 encodings
//   bht_cnt_t : 2-bit saturating direction counter
//   cnt_train : saturating counter update (never wraps)
package branch_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } br_op_e;

    typedef logic [1:0] bht_cnt_t;

    localparam bht_cnt_t CNT_SNT = 2'd0;
    localparam bht_cnt_t CNT_WNT = 2'd1;
    localparam bht_cnt_t CNT_WT  = 2'd2;
    localparam bht_cnt_t CNT_ST  = 2'd3;

    function automatic bht_cnt_t cnt_train(input bht_cnt_t cnt, input logic taken);
        if (taken) begin
            return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
        end
        return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/bht_table.sv
// Bimodal history table: array of 2-bit saturating counters.
//   clk, rst_n : clock, async active-low reset (all counters -> CNT_INIT)
//   rd_idx     : combinational read index
//   rd_cnt     : counter at rd_idx (pre-update value; no write bypass)
//   wr_en      : train the counter at wr_idx on the next rising edge
//   wr_idx     : training index
//   wr_taken   : actual outcome used for training
module bht_table
    import branch_pkg::*;
#(
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned CNT_INIT    = 1,
    localparam int unsigned IDX_W      = $clog2(BHT_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output bht_cnt_t         rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    bht_cnt_t cnt_q [BHT_ENTRIES];
    bht_cnt_t cnt_d [BHT_ENTRIES];

    always_comb begin
        cnt_d = cnt_q;
        if (wr_en) begin
            cnt_d[wr_idx] = cnt_train(cnt_q[wr_idx], wr_taken);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                cnt_q[i] <= bht_cnt_t'(CNT_INIT);
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Reads the registered array, so a same-cycle update is not visible.
    assign rd_cnt = cnt_q[rd_idx];

endmodule

// File: rtl/branch_predict_unit.sv
// Branch resolution plus bimodal direction prediction.
//   Fetch:   f_pc -> f_pred_taken (combinational, counter MSB)
//   Execute: ex_* resolves an RV32I conditional branch, trains the table and
//            reports a registered result on rs_* one cycle later.
//   rs_next_pc holds its value when nothing resolves.
// Optional feature macro: BRANCH_STATS_EN adds stat_branches / stat_mispredicts
// (legal resolved branches / legal mispredicts, wrapping 32-bit counters).
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned CNT_INIT    = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] f_pc,
    output logic            f_pred_taken,
    input  logic            ex_valid,
    input  logic            ex_branch,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_rd1,
    input  logic [XLEN-1:0] ex_rd2,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic            ex_pred_taken,
    output logic            rs_valid,
    output logic            rs_taken,
    output logic            rs_mispredict,
    output logic [XLEN-1:0] rs_next_pc,
    output logic            rs_illegal
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] ex_idx;
    bht_cnt_t         f_cnt;
    logic             resolve;
    logic             legal_resolve;
    logic             cond_taken;
    logic             br_illegal;
    logic             actual_taken;
    logic [XLEN-1:0]  target_pc;
    logic [XLEN-1:0]  fallthru_pc;

    logic            rs_valid_q, rs_valid_d;
    logic            rs_taken_q, rs_taken_d;
    logic            rs_mispredict_q, rs_mispredict_d;
    logic            rs_illegal_q, rs_illegal_d;
    logic [XLEN-1:0] rs_next_pc_q, rs_next_pc_d;

    assign f_idx  = f_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];

    // Only the index bits of f_pc participate.
    logic unused_f_pc;
    assign unused_f_pc = ^{f_pc[XLEN-1:IDX_W+2], f_pc[1:0]};

    bht_table #(
        .BHT_ENTRIES (BHT_ENTRIES),
        .CNT_INIT    (CNT_INIT)
    ) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (f_idx),
        .rd_cnt   (f_cnt),
        .wr_en    (legal_resolve),
        .wr_idx   (ex_idx),
        .wr_taken (cond_taken)
    );

    assign f_pred_taken = f_cnt[1];

    always_comb begin
        cond_taken = 1'b0;
        br_illegal = 1'b0;
        case (ex_funct3)
            BEQ:     cond_taken = (ex_rd1 == ex_rd2);
            BNE:     cond_taken = (ex_rd1 != ex_rd2);
            BLT:     cond_taken = ($signed(ex_rd1) <  $signed(ex_rd2));
            BGE:     cond_taken = ($signed(ex_rd1) >= $signed(ex_rd2));
            BLTU:    cond_taken = (ex_rd1 <  ex_rd2);
            BGEU:    cond_taken = (ex_rd1 >= ex_rd2);
            default: br_illegal = 1'b1;
        endcase
    end

    assign resolve       = ex_valid & ex_branch;
    assign legal_resolve = resolve & ~br_illegal;
    assign actual_taken  = cond_taken & ~br_illegal;

    // Modulo-2^XLEN arithmetic; wrap-around is intentional.
    assign target_pc   = ex_pc + ex_imm;
    assign fallthru_pc = ex_pc + XLEN'(4);

    always_comb begin
        rs_valid_d      = resolve;
        rs_taken_d      = resolve & actual_taken;
        rs_mispredict_d = resolve & (actual_taken != ex_pred_taken);
        rs_illegal_d    = resolve & br_illegal;
        rs_next_pc_d    = rs_next_pc_q;
        if (resolve) begin
            rs_next_pc_d = actual_taken ? target_pc : fallthru_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_valid_q      <= 1'b0;
            rs_taken_q      <= 1'b0;
            rs_mispredict_q <= 1'b0;
            rs_illegal_q    <= 1'b0;
            rs_next_pc_q    <= '0;
        end else begin
            rs_valid_q      <= rs_valid_d;
            rs_taken_q      <= rs_taken_d;
            rs_mispredict_q <= rs_mispredict_d;
            rs_illegal_q    <= rs_illegal_d;
            rs_next_pc_q    <= rs_next_pc_d;
        end
    end

    assign rs_valid      = rs_valid_q;
    assign rs_taken      = rs_taken_q;
    assign rs_mispredict = rs_mispredict_q;
    assign rs_illegal    = rs_illegal_q;
    assign rs_next_pc    = rs_next_pc_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_br_q, stat_br_d;
    logic [31:0] stat_mis_q, stat_mis_d;

    always_comb begin
        stat_br_d  = stat_br_q;
        stat_mis_d = stat_mis_q;
        if (legal_resolve) begin
            stat_br_d = stat_br_q + 32'd1;
            if (actual_taken != ex_pred_taken) begin
                stat_mis_d = stat_mis_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            stat_br_q  <= stat_br_d;
            stat_mis_q <= stat_mis_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit (default parameters).
module tb_branch_predict_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] f_pc;
    logic        f_pred_taken;
    logic        ex_valid;
    logic        ex_branch;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_rd1;
    logic [31:0] ex_rd2;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic        ex_pred_taken;
    logic        rs_valid;
    logic        rs_taken;
    logic        rs_mispredict;
    logic [31:0] rs_next_pc;
    logic        rs_illegal;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    branch_predict_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .f_pc          (f_pc),
        .f_pred_taken  (f_pred_taken),
        .ex_valid      (ex_valid),
        .ex_branch     (ex_branch),
        .ex_funct3     (ex_funct3),
        .ex_rd1        (ex_rd1),
        .ex_rd2        (ex_rd2),
        .ex_pc         (ex_pc),
        .ex_imm        (ex_imm),
        .ex_pred_taken (ex_pred_taken),
        .rs_valid      (rs_valid),
        .rs_taken      (rs_taken),
        .rs_mispredict (rs_mispredict),
        .rs_next_pc    (rs_next_pc),
        .rs_illegal    (rs_illegal)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic        taken;
        logic        mispred;
        logic        illegal;
        logic [31:0] npc;
    } rs_exp_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic        taken;
        logic        illegal;
    } vec_t;

    rs_exp_t     sb_q[$];
    logic [31:0] npc_hold;
    logic [1:0]  ref_cnt [64];
    int          checks;
    int          failures;
    vec_t        vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) ref_cnt[i] = 2'd1;
        npc_hold = 32'h0;
    endtask

    // One clock: drive execute inputs and f_pc, check the pre-edge prediction,
    // push the expected rs_* record, then pop and compare after the edge.
    task automatic cycle(input logic br, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm,
                         input logic pred, input logic exp_taken, input logic [31:0] fpc);
        rs_exp_t e;
        rs_exp_t got;
        logic    ill;
        @(negedge clk);
        ex_valid = br; ex_branch = br; ex_funct3 = f3; ex_rd1 = a; ex_rd2 = b;
        ex_pc = pc; ex_imm = imm; ex_pred_taken = pred; f_pc = fpc;
        #1;
        check("f_pred_taken", {31'h0, f_pred_taken}, {31'h0, ref_cnt[fpc[7:2]][1]});
        ill = br && (f3 == 3'b010 || f3 == 3'b011);
        if (br) begin
            npc_hold  = exp_taken ? pc + imm : pc + 32'd4;
            e.valid   = 1'b1;
            e.taken   = exp_taken;
            e.mispred = (exp_taken != pred);
            e.illegal = ill;
            if (!ill) begin
                if (exp_taken && ref_cnt[pc[7:2]] != 2'd3) ref_cnt[pc[7:2]]++;
                if (!exp_taken && ref_cnt[pc[7:2]] != 2'd0) ref_cnt[pc[7:2]]--;
            end
        end else begin
            e = '0;
        end
        e.npc = npc_hold;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        got = {rs_valid, rs_taken, rs_mispredict, rs_illegal, rs_next_pc};
        check("rs_valid", {31'h0, got.valid}, {31'h0, e.valid});
        check("rs_taken", {31'h0, got.taken}, {31'h0, e.taken});
        check("rs_mispredict", {31'h0, got.mispred}, {31'h0, e.mispred});
        check("rs_illegal", {31'h0, got.illegal}, {31'h0, e.illegal});
        check("rs_next_pc", got.npc, e.npc);
    endtask

    task automatic idle(input logic [31:0] fpc);
        cycle(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, fpc);
    endtask

    initial begin
        checks = 0; failures = 0;
        vecs[0]  = '{3'b101, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0};  // BGE -1 >= 1
        vecs[1]  = '{3'b111, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0};  // BGEU
        vecs[2]  = '{3'b101, 32'h7, 32'h7, 1'b1, 1'b0};          // BGE equal
        vecs[3]  = '{3'b000, 32'h3, 32'h4, 1'b0, 1'b0};
        vecs[4]  = '{3'b001, 32'h3, 32'h4, 1'b1, 1'b0};
        vecs[5]  = '{3'b001, 32'h9, 32'h9, 1'b0, 1'b0};
        vecs[6]  = '{3'b100, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0};
        vecs[7]  = '{3'b100, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[8]  = '{3'b110, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0};
        vecs[9]  = '{3'b110, 32'h1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[10] = '{3'b111, 32'h5, 32'h5, 1'b1, 1'b0};
        vecs[11] = '{3'b100, 32'h5, 32'h5, 1'b0, 1'b0};
        vecs[12] = '{3'b010, 32'h6, 32'h6, 1'b0, 1'b1};
        vecs[13] = '{3'b011, 32'h6, 32'h6, 1'b0, 1'b1};

        ex_valid = 0; ex_branch = 0; ex_funct3 = 0; ex_rd1 = 0; ex_rd2 = 0;
        ex_pc = 0; ex_imm = 0; ex_pred_taken = 0; f_pc = 32'h100;
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #10;
        check("reset rs_valid", {31'h0, rs_valid}, 32'h0);
        check("reset rs_taken", {31'h0, rs_taken}, 32'h0);
        check("reset rs_mispredict", {31'h0, rs_mispredict}, 32'h0);
        check("reset rs_illegal", {31'h0, rs_illegal}, 32'h0);
        check("reset rs_next_pc", rs_next_pc, 32'h0);
        check("reset pred 0x100", {31'h0, f_pred_taken}, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // Train 0x100 up to saturation, then one step down: still predicts taken.
        repeat (3) cycle(1'b1, 3'b000, 32'h5, 32'h5, 32'h100, 32'h40, 1'b0, 1'b1, 32'h100);
        cycle(1'b1, 3'b000, 32'h5, 32'h6, 32'h100, 32'h40, 1'b1, 1'b0, 32'h100);
        idle(32'h100);
        check("pred 0x100 after sat+dec", {31'h0, f_pred_taken}, 32'h1);

        for (int i = 0; i < 14; i++) begin
            cycle(1'b1, vecs[i].f3, vecs[i].a, vecs[i].b, 32'h1080 + 32'(i * 4), 32'h20,
                  1'(i % 2), vecs[i].taken, 32'h1080 + 32'(i * 4));
            check("vec illegal", {31'h0, rs_illegal}, {31'h0, vecs[i].illegal});
        end
        idle(32'h10B0);  // illegal 010 entry: counter must still be at init
        check("illegal no train", {31'h0, f_pred_taken}, 32'h0);

        // Negative-offset taken branch, mispredicted; then result drops out.
        cycle(1'b1, 3'b000, 32'h1, 32'h1, 32'h200, 32'hFFFF_FFF0, 1'b0, 1'b1, 32'h200);
        check("neg imm next_pc", rs_next_pc, 32'h1F0);
        idle(32'h200);
        check("valid drops", {31'h0, rs_valid}, 32'h0);

        // Low saturation at 0x40, then same-cycle read/write with no bypass.
        repeat (3) cycle(1'b1, 3'b001, 32'h2, 32'h2, 32'h40, 32'h8, 1'b0, 1'b0, 32'h40);
        cycle(1'b1, 3'b001, 32'h2, 32'h3, 32'h40, 32'h8, 1'b0, 1'b1, 32'h40);
        idle(32'h40);
        check("pred 0x40 after one up", {31'h0, f_pred_taken}, 32'h0);

        // Wrap-around at the top of the address space.
        cycle(1'b1, 3'b000, 32'h0, 32'h0, 32'hFFFF_FFF8, 32'h10, 1'b1, 1'b1, 32'h0);

        // Asynchronous reset while a result is presented and another is in flight.
        @(negedge clk);
        ex_valid = 1; ex_branch = 1; ex_funct3 = 3'b000; ex_rd1 = 1; ex_rd2 = 1;
        ex_pc = 32'h300; ex_imm = 32'h10;
        check("pre-reset rs_valid", {31'h0, rs_valid}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("mid reset rs_valid", {31'h0, rs_valid}, 32'h0);
        check("mid reset rs_next_pc", rs_next_pc, 32'h0);
        ex_valid = 0; ex_branch = 0;
        @(posedge clk);
        #1;
        check("held reset rs_valid", {31'h0, rs_valid}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 64; i++) begin
            f_pc = 32'(i * 4);
            #1;
            check("post reset pred", {31'h0, f_pred_taken}, 32'h0);
        end

`ifdef BRANCH_STATS_EN
        cycle(1'b1, 3'b000, 32'h1, 32'h1, 32'h400, 32'h8, 1'b1, 1'b1, 32'h400);
        cycle(1'b1, 3'b000, 32'h1, 32'h1, 32'h404, 32'h8, 1'b0, 1'b1, 32'h404);
        cycle(1'b1, 3'b001, 32'h1, 32'h1, 32'h408, 32'h8, 1'b0, 1'b0, 32'h408);
        cycle(1'b1, 3'b001, 32'h1, 32'h2, 32'h40C, 32'h8, 1'b0, 1'b1, 32'h40C);
        cycle(1'b1, 3'b011, 32'h1, 32'h1, 32'h410, 32'h8, 1'b1, 1'b0, 32'h410);
        cycle(1'b1, 3'b110, 32'h1, 32'h2, 32'h414, 32'h8, 1'b1, 1'b1, 32'h414);
        check("stat_branches", stat_branches, 32'd5);
        check("stat_mispredicts", stat_mispredicts, 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
